// File: rtl/alarm_buzzer.sv
// Alarm buzzer: edge-triggered ring with stop key, ring timeout and gated square-wave tone.
// Optional snooze (SNOOZE state, limited count) is built only when ALARM_SNOOZE_EN is defined.
module alarm_buzzer #(
    parameter int TONE_HALF  = 12500,
    parameter int BEEP_HALF  = 12500000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int SNOOZE_MAX = 3
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       sec_en_i,
    input  logic       alarm_i,
    input  logic       stop_i,
    input  logic       snz_i,
    output logic       buzz_o,
    output logic       ringing_o,
    output logic       snoozing_o,
    output logic [1:0] snz_left_o
);

    localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SEC_W   = (SEC_MAX   > 1) ? $clog2(SEC_MAX)   : 1;
    localparam int TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int BEEP_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

    localparam logic [SEC_W-1:0]  RING_LAST = SEC_W'(RING_SEC - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);
    localparam logic [1:0]        SNZ_MAX   = SNOOZE_MAX[1:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE = 2'd2,
`endif
        ST_RING   = 2'd1
    } state_e;

    state_e              state_q, state_d;
    logic                alarm_q;
    logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;
    logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic                tone_q, tone_d;
    logic                beep_q, beep_d;
    logic                buzz_q, ringing_q;
    logic                rise;
    logic                enter_ring;

`ifdef ALARM_SNOOZE_EN
    localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
    logic       snoozing_q;
    logic [1:0] snz_left_q, snz_left_d;
`endif

    // Only a fresh match starts ringing, so a stop/timeout inside the match minute stays quiet.
    assign rise = alarm_i & ~alarm_q;

    always_comb begin
        state_d    = state_q;
        sec_cnt_d  = sec_cnt_q;
        enter_ring = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_left_d = snz_left_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef ALARM_SNOOZE_EN
                snz_left_d = SNZ_MAX;
`endif
                if (rise) begin
                    state_d    = ST_RING;
                    enter_ring = 1'b1;
                    sec_cnt_d  = '0;
                end
            end
            ST_RING: begin
                if (stop_i) begin
                    state_d   = ST_IDLE;
                    sec_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
                end else if (snz_i && (snz_left_q != 2'd0)) begin
                    state_d    = ST_SNOOZE;
                    snz_left_d = snz_left_q - 2'd1;
                    sec_cnt_d  = '0;
`endif
                end else if (sec_en_i) begin
                    if (sec_cnt_q == RING_LAST) begin
                        state_d   = ST_IDLE;
                        sec_cnt_d = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 1'b1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (stop_i) begin
                    state_d   = ST_IDLE;
                    sec_cnt_d = '0;
                end else if (sec_en_i) begin
                    if (sec_cnt_q == SNOOZE_LAST) begin
                        state_d    = ST_RING;
                        enter_ring = 1'b1;
                        sec_cnt_d  = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d   = ST_IDLE;
                sec_cnt_d = '0;
            end
        endcase
    end

    // Tone and beep generators restart high on every RING entry and idle low elsewhere.
    always_comb begin
        tone_cnt_d = '0;
        beep_cnt_d = '0;
        tone_d     = 1'b0;
        beep_d     = 1'b0;
        if (enter_ring) begin
            tone_d = 1'b1;
            beep_d = 1'b1;
        end else if (state_d == ST_RING) begin
            if (tone_cnt_q == TONE_LAST) begin
                tone_cnt_d = '0;
                tone_d     = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 1'b1;
                tone_d     = tone_q;
            end
            if (beep_cnt_q == BEEP_LAST) begin
                beep_cnt_d = '0;
                beep_d     = ~beep_q;
            end else begin
                beep_cnt_d = beep_cnt_q + 1'b1;
                beep_d     = beep_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            alarm_q    <= 1'b0;
            sec_cnt_q  <= '0;
            tone_cnt_q <= '0;
            beep_cnt_q <= '0;
            tone_q     <= 1'b0;
            beep_q     <= 1'b0;
            buzz_q     <= 1'b0;
            ringing_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snoozing_q <= 1'b0;
            snz_left_q <= SNZ_MAX;
`endif
        end else begin
            state_q    <= state_d;
            alarm_q    <= alarm_i;
            sec_cnt_q  <= sec_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            beep_cnt_q <= beep_cnt_d;
            tone_q     <= tone_d;
            beep_q     <= beep_d;
            buzz_q     <= (state_d == ST_RING) & tone_d & beep_d;
            ringing_q  <= (state_d == ST_RING);
`ifdef ALARM_SNOOZE_EN
            snoozing_q <= (state_d == ST_SNOOZE);
            snz_left_q <= snz_left_d;
`endif
        end
    end

    assign buzz_o    = buzz_q;
    assign ringing_o = ringing_q;

`ifdef ALARM_SNOOZE_EN
    assign snoozing_o = snoozing_q;
    assign snz_left_o = snz_left_q;
`else
    // Snooze key and count have no function in this build.
    logic [2:0] snz_unused;
    assign snz_unused = {snz_i, SNZ_MAX};
    assign snoozing_o = 1'b0;
    assign snz_left_o = 2'd0;
`endif

endmodule

// File: tb/tb_alarm_buzzer.sv
// Self-checking bench for alarm_buzzer: directed scenarios plus random stimulus vs. a behavioural model.
module tb_alarm_buzzer;

    localparam int TONE_HALF  = 2;
    localparam int BEEP_HALF  = 8;
    localparam int RING_SEC   = 4;
    localparam int SNOOZE_SEC = 3;
    localparam int SNOOZE_MAX = 2;
    localparam int SEC_PERIOD = 20;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sec_en = 1'b0;
    logic       alarm = 1'b0;
    logic       stop = 1'b0;
    logic       snz = 1'b0;
    logic       buzz, ringing, snoozing;
    logic [1:0] snz_left;
    logic [4:0] dut_v;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model: mode, seconds elapsed in mode, cycles since ring entry, snoozes left.
    int m_st = M_IDLE;
    int m_ticks = 0;
    int m_k = 0;
    int m_left = SNOOZE_MAX;
    bit m_prev = 1'b0;

    alarm_buzzer #(
        .TONE_HALF (TONE_HALF),
        .BEEP_HALF (BEEP_HALF),
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .SNOOZE_MAX(SNOOZE_MAX)
    ) dut (
        .clk_i     (clk),
        .reset_ni  (reset_n),
        .sec_en_i  (sec_en),
        .alarm_i   (alarm),
        .stop_i    (stop),
        .snz_i     (snz),
        .buzz_o    (buzz),
        .ringing_o (ringing),
        .snoozing_o(snoozing),
        .snz_left_o(snz_left)
    );

    always #5 clk = ~clk;
    assign dut_v = {buzz, ringing, snoozing, snz_left};

    task automatic model_step();
        bit rise;
        rise = alarm && !m_prev;
        if (!reset_n) begin
            m_st = M_IDLE; m_ticks = 0; m_k = 0; m_left = SNOOZE_MAX; m_prev = 1'b0;
        end else begin
            m_prev = alarm;
            if (m_st == M_IDLE) m_left = SNOOZE_MAX;
            case (m_st)
                M_IDLE: if (rise) begin m_st = M_RING; m_k = 0; m_ticks = 0; end
                M_RING: begin
                    if (stop) begin
                        m_st = M_IDLE; m_ticks = 0;
                    end else if (SNZ_EN && snz && m_left > 0) begin
                        m_st = M_SNZ; m_left--; m_ticks = 0;
                    end else begin
                        m_k++;
                        if (sec_en) begin
                            if (m_ticks == RING_SEC - 1) begin m_st = M_IDLE; m_ticks = 0; end
                            else m_ticks++;
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        m_st = M_IDLE; m_ticks = 0;
                    end else if (sec_en) begin
                        if (m_ticks == SNOOZE_SEC - 1) begin m_st = M_RING; m_k = 0; m_ticks = 0; end
                        else m_ticks++;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [4:0] exp_out();
        bit tone_on, beep_on, ring;
        logic [1:0] left;
        tone_on = ((m_k / TONE_HALF) % 2) == 0;
        beep_on = ((m_k / BEEP_HALF) % 2) == 0;
        ring    = (m_st == M_RING);
        left    = SNZ_EN ? 2'(m_left) : 2'd0;
        return {ring && tone_on && beep_on, ring, m_st == M_SNZ, left};
    endfunction

    task automatic cycle(input bit a, input bit st, input bit sz, input bit rn);
        alarm = a; stop = st; snz = sz; reset_n = rn;
        sec_en = (cyc % SEC_PERIOD) == SEC_PERIOD - 1;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    // Stop any ring/snooze with ALARM low, then raise ALARM to produce a fresh rise.
    task automatic start_ring();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (dut_v !== exp_out()) begin
                fails++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, dut_v, exp_out());
            end
            checks++;
            if (snz_left !== (SNZ_EN ? 2'd2 : 2'd0) || ringing !== 1'b0 || buzz !== 1'b0) begin
                fails++; $display("FAIL reset_values got left=%0d ring=%b buzz=%b", snz_left, ringing, buzz);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ringing !== 1'b1 || buzz !== 1'b1) begin
            fails++; $display("FAIL reset_release_rise got ring=%b buzz=%b exp ring=1 buzz=1", ringing, buzz);
        end
    endtask

    task automatic test_ring_timeout();
        bit pat;
        start_ring();
        for (int i = 0; i < 100; i++) begin
            // Expected tone from the spec: 1,1,0,0 for 8 cycles, then 8 silent cycles.
            pat = (i < 4 * SEC_PERIOD) && ((i % 16) < 8) && ((i % 4) < 2);
            if (i < 40) begin
                checks++;
                if (buzz !== pat) begin
                    fails++; $display("FAIL tone_pattern i=%0d got=%b exp=%b", i, buzz, pat);
                end
            end
            checks++;
            if (dut_v !== exp_out()) begin
                fails++; $display("FAIL ring_timeout cyc=%0d got=%b exp=%b", cyc, dut_v, exp_out());
            end
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (ringing !== 1'b0 || buzz !== 1'b0) begin
            fails++; $display("FAIL no_reringing got ring=%b buzz=%b exp 0", ringing, buzz);
        end
    endtask

    task automatic test_snooze();
        start_ring();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
            cycle(1'b1, 1'b0, 1'b1, 1'b1);
            checks++;
            if (dut_v !== exp_out()) begin
                fails++; $display("FAIL snooze_press n=%0d got=%b exp=%b", n, dut_v, exp_out());
            end
            for (int i = 0; i < 70; i++) begin
                cycle(1'b1, 1'b0, 1'b0, 1'b1);
                checks++;
                if (dut_v !== exp_out()) begin
                    fails++; $display("FAIL snooze_run cyc=%0d got=%b exp=%b", cyc, dut_v, exp_out());
                end
            end
        end
    endtask

    task automatic test_stop_snz();
        start_ring();
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (dut_v !== exp_out() || ringing !== 1'b0 || snoozing !== 1'b0) begin
            fails++; $display("FAIL stop_beats_snz got=%b exp=%b", dut_v, exp_out());
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (snz_left !== (SNZ_EN ? 2'd2 : 2'd0)) begin
            fails++; $display("FAIL snz_left_reload got=%0d exp=%0d", snz_left, SNZ_EN ? 2 : 0);
        end
    endtask

    task automatic test_snz_timeout();
        bit hit = 1'b0;
        start_ring();
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_st == M_RING && m_ticks == RING_SEC - 1 && (cyc % SEC_PERIOD) == SEC_PERIOD - 1) begin
                cycle(1'b1, 1'b0, 1'b1, 1'b1);
                hit = 1'b1;
            end else begin
                cycle(1'b1, 1'b0, 1'b0, 1'b1);
            end
        end
        checks++;
        if (!hit) begin
            fails++; $display("FAIL snz_timeout_bound got no 4th tick exp one within 200 cycles");
        end
        checks++;
        if (snoozing !== SNZ_EN || ringing !== 1'b0) begin
            fails++; $display("FAIL snz_beats_timeout got snoozing=%b ring=%b exp snoozing=%b", snoozing, ringing, SNZ_EN);
        end
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (dut_v !== exp_out() || ringing !== 1'b0) begin
                fails++; $display("FAIL stop_in_snooze cyc=%0d got=%b exp=%b", cyc, dut_v, exp_out());
            end
        end
    endtask

    task automatic test_random();
        bit a = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) a = ~a;
            cycle(a, $urandom_range(0, 79) == 0, $urandom_range(0, 14) == 0,
                  $urandom_range(0, 399) != 0);
            checks++;
            if (dut_v !== exp_out()) begin
                fails++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_v, exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_stop_snz();
        test_snz_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
